// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch unit: registered PC, zero-wait memory, small FIFO toward decode
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] PC,
  input  logic [31:0] Instruction,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = (QDEPTH > 2) ? $clog2(QDEPTH) : 1;
  localparam logic [CW-1:0] FULL     = CW'(QDEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(QDEPTH - 1);
  localparam logic [31:0]   ALIGN    = 32'hFFFF_FFFC;

  logic [31:0]   q_pc   [QDEPTH];
  logic [31:0]   q_inst [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   hold_pc;
  logic [31:0]   hold_inst;
  logic          pop;
  logic          push;

  // Pointers wrap at QDEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign inst_valid = (count != '0);
  assign pop        = inst_valid & inst_ready;
  // A redirect suppresses the fetch of the stale PC; a full queue only accepts if the head leaves.
  assign push       = !redirect && ((count != FULL) || pop);

  // Head view: live entry while occupied, otherwise the last head seen so decode sees stable data.
  always_comb begin
    inst_out = hold_inst;
    inst_pc  = hold_pc;
    if (inst_valid) begin
      inst_out = q_inst[rd_ptr];
      inst_pc  = q_pc[rd_ptr];
    end
  end

  // Queue storage has no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= PC;
      q_inst[wr_ptr] <= Instruction;
    end
  end

  // Control state: PC, pointers, occupancy and the held head copy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      PC        <= RESET_PC & ALIGN;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      hold_pc   <= '0;
      hold_inst <= '0;
    end else begin
      if (inst_valid) begin
        hold_pc   <= q_pc[rd_ptr];
        hold_inst <= q_inst[rd_ptr];
      end
      if (redirect) begin
        PC     <= redirect_target & ALIGN;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (pop) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        if (push) begin
          wr_ptr <= ptr_inc(wr_ptr);
          PC     <= PC + 32'd4;
        end
        if (push && !pop) begin
          count <= count + CW'(1);
        end else if (pop && !push) begin
          count <= count - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - randomized scoreboard bench for ifetch against a queue-level fetch model
module tb_ifetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;

  int checks = 0;
  int failures = 0;

  ent_t        exp_q[$];
  logic [31:0] model_pc = RESET_PC;
  ent_t        last_head = '{32'h0, 32'h0};

  ifetch #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk(clk),
    .rstn(rstn),
    .PC(PC),
    .Instruction(Instruction),
    .inst_valid(inst_valid),
    .inst_out(inst_out),
    .inst_pc(inst_pc),
    .inst_ready(inst_ready),
    .redirect(redirect),
    .redirect_target(redirect_target)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: word i holds 0x1000 + i.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  assign Instruction = mem_word(PC);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fetch queue of {pc, word} entries, bounded by QDEPTH.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_q.delete();
      model_pc  = RESET_PC;
      last_head = '{32'h0, 32'h0};
    end else begin
      if (exp_q.size() != 0) last_head = exp_q[0];
      if (exp_q.size() != 0 && inst_ready) void'(exp_q.pop_front());
      if (redirect) begin
        exp_q.delete();
        model_pc = {redirect_target[31:2], 2'b00};
      end else if (exp_q.size() < QDEPTH) begin
        exp_q.push_back('{model_pc, mem_word(model_pc)});
        model_pc = model_pc + 32'd4;
      end
    end
  end

  // Monitor: compares the DUT's presented head and PC against the model every cycle.
  always @(negedge clk) begin
    if (rstn) begin
      check("inst_valid", {31'b0, inst_valid}, {31'b0, exp_q.size() != 0});
      check("PC", PC, model_pc);
      if (exp_q.size() != 0) begin
        check("head_pc", inst_pc, exp_q[0].pc);
        check("head_inst", inst_out, exp_q[0].inst);
      end else begin
        check("hold_pc", inst_pc, last_head.pc);
        check("hold_inst", inst_out, last_head.inst);
      end
    end
  end

  // Apply inputs for one edge, then return 1 time unit after that edge.
  task automatic drive(input logic r, input logic rd, input logic [31:0] tgt);
    inst_ready      = r;
    redirect        = rd;
    redirect_target = tgt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    check("rst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_pc", PC, RESET_PC);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_inst_out", inst_out, 32'h0);
    rstn = 1'b1;

    // First edge after reset fetches RESET_PC; then backpressure fills the queue.
    drive(1'b0, 1'b0, 32'h0);
    check("first_valid", {31'b0, inst_valid}, 32'h1);
    check("first_pc", inst_pc, RESET_PC);
    repeat (4) drive(1'b0, 1'b0, 32'h0);
    check("bp_pc_hold", PC, 32'h8);
    check("bp_head", inst_pc, 32'h0);

    // Release: drain in order with one entry per cycle.
    drive(1'b1, 1'b0, 32'h0);
    check("drain_1", inst_pc, 32'h4);
    drive(1'b1, 1'b0, 32'h0);
    check("drain_2", inst_pc, 32'h8);
    drive(1'b1, 1'b0, 32'h0);
    check("drain_3", inst_pc, 32'hC);
    check("drain_3_inst", inst_out, 32'h1003);
    repeat (6) drive(1'b1, 1'b0, 32'h0);

    // Redirect while full.
    repeat (2) drive(1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 32'h40);
    check("redir_bubble", {31'b0, inst_valid}, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    check("redir_tgt", inst_pc, 32'h40);
    drive(1'b1, 1'b0, 32'h0);
    check("redir_next", inst_pc, 32'h44);

    // Misaligned target.
    drive(1'b1, 1'b1, 32'h43);
    drive(1'b1, 1'b0, 32'h0);
    check("misalign_pc", inst_pc, 32'h40);
    check("misalign_inst", inst_out, 32'h1010);

    // Address wrap.
    drive(1'b1, 1'b1, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 32'h0);
    check("wrap_a", inst_pc, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 32'h0);
    check("wrap_b", inst_pc, 32'h0000_0000);

    // Back-to-back redirects: only the last target is fetched.
    drive(1'b1, 1'b1, 32'h100);
    drive(1'b1, 1'b1, 32'h200);
    check("b2b_bubble", {31'b0, inst_valid}, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    check("b2b_tgt", inst_pc, 32'h200);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), $urandom);
    end

    // Mid-run asynchronous reset while full.
    repeat (3) drive(1'b0, 1'b0, 32'h0);
    #2;
    rstn = 1'b0;
    #1;
    check("mrst_valid", {31'b0, inst_valid}, 32'h0);
    check("mrst_pc", PC, RESET_PC);
    check("mrst_inst_pc", inst_pc, 32'h0);
    check("mrst_inst_out", inst_out, 32'h0);
    rstn = 1'b1;
    drive(1'b1, 1'b0, 32'h0);
    check("restart_pc", inst_pc, RESET_PC);
    check("restart_valid", {31'b0, inst_valid}, 32'h1);
    repeat (5) drive(1'b1, 1'b0, 32'h0);

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002 The block SHALL have parameter QDEPTH, default 2, which is the instruction queue depth (legal 2..8).
REQ-003 The block SHALL have port clk, input, 1, which is the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1, which is an asynchronous, active-low reset.
REQ-005 The block SHALL have port PC, output, 32, which is the fetch address driven to the instruction memory address input.
REQ-006 The block SHALL have port Instruction, input, 32, which is the word returned combinationally by instruction memory for the current PC.
REQ-007 The block SHALL have port inst_valid, output, 1, which means the queue head holds a valid instruction.
REQ-008 The block SHALL have port inst_out, output, 32, which is the instruction word at the queue head.
REQ-009 The block SHALL have port inst_pc, output, 32, which is the fetch address of inst_out.
REQ-010 The block SHALL have port inst_ready, input, 1, which means the decode stage accepts the head this cycle.
REQ-011 The block SHALL have port redirect, input, 1, which requests a branch/jump/flush.
REQ-012 The block SHALL have port redirect_target, input, 32, which is the new fetch address, valid when redirect=1.

Function
REQ-013 PC SHALL be a register; Instruction is sampled in the same cycle PC is presented (zero-wait memory).
REQ-014 Pop SHALL occur when inst_valid=1 and inst_ready=1 at a rising edge; the entry is removed at that edge.
REQ-015 Push SHALL occur at a rising edge when redirect=0 and (occupancy<QDEPTH or a pop occurs that edge); the entry written is {PC, Instruction}, and PC advances by 32'd4.
REQ-016 When occupancy=QDEPTH and no pop occurs, the block SHALL NOT push, and PC SHALL hold its value (stall).
REQ-017 Simultaneous push and pop SHALL leave occupancy unchanged; the queue SHALL preserve FIFO order.
REQ-018 inst_valid SHALL equal (occupancy!=0); inst_out and inst_pc SHALL reflect the head entry; when empty, both SHALL hold their last value (0 after reset).
REQ-019 On redirect=1 at an edge: the queue SHALL be flushed (occupancy 0), PC SHALL load {redirect_target[31:2],2'b00}, and no push SHALL occur; a pop handshake in the same cycle counts as completed.
REQ-020 Redirect latency: on redirect at edge N, inst_valid SHALL be 0 after N, the target SHALL be pushed at N+1, and inst_valid=1 with inst_pc=target SHALL hold after N+1.
REQ-021 Back-to-back redirects SHALL each take effect; only the last target SHALL be fetched.
REQ-022 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 gives 32'h0000_0000 with no flag.
REQ-023 PC[1:0] SHALL always be 2'b00; no address range check is performed (memory indexes PC>>2).
REQ-024 Occupancy counter width SHALL be clog2(QDEPTH+1); read/write pointers SHALL wrap modulo QDEPTH.
REQ-025 Throughput SHALL be one instruction per cycle when inst_ready is held at 1 and redirect is held at 0.

Reset
REQ-026 rstn=0 SHALL immediately, independent of clk, force PC=RESET_PC, occupancy=0, inst_valid=0, inst_out=0, and inst_pc=0.
REQ-027 Reset asserted mid-operation SHALL discard all queued entries and any pending redirect.
REQ-028 The first push SHALL occur at the first rising edge with rstn=1 (address RESET_PC), giving inst_valid=1 after that edge.

Verification
REQ-029 The bench SHALL cover streaming: memory holds words 0x1000+i with inst_ready=1, so inst_pc=0,4,8,... one per cycle and inst_out matches each address.
REQ-030 The bench SHALL cover backpressure: with inst_ready=0 for 5 cycles, occupancy reaches 2, PC holds at 8 and inst_pc stays 0; releasing inst_ready drains 0,4, then 8 with no gaps or duplicates.
REQ-031 The bench SHALL cover redirect: redirect=1 with target 0x40 while the queue holds 2 entries gives inst_valid=0 for 1 cycle, then inst_pc=0x40, 0x44.
REQ-032 The bench SHALL cover a misaligned target: redirect_target=0x43 gives a fetch at 0x40.
REQ-033 The bench SHALL cover wrap: redirect to 0xFFFF_FFFC gives inst_pc sequence 0xFFFF_FFFC, 0x0000_0000.
REQ-034 The bench SHALL cover mid-run reset: rstn pulsed low between edges while full gives an immediate inst_valid=0 and PC=RESET_PC, then restart at RESET_PC.
